// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_CNT_W  = 64;
  localparam int unsigned DEF_REG_AW = 5;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_CNT_W-1:0]  word_t;
  typedef logic [DEF_REG_AW-1:0] reg_addr_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic en;
    logic bubble;
  } stage_ctrl_t;

  // Winning hazard for the current cycle, highest priority first.
  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_MEM_STALL  = 3'd1,
    CAUSE_REDIRECT   = 3'd2,
    CAUSE_LOAD_USE   = 3'd3,
    CAUSE_FETCH_WAIT = 3'd4
  } hazard_cause_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard conditions: data-memory stall, load-use, usable redirect.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              dmem_busy,
  input  logic              ex_redirect,
  output logic              mem_stall,
  output logic              load_use,
  output logic              redirect_ok
);

  assign mem_stall   = mem_valid & dmem_busy;
  assign load_use    = ex_valid & ex_is_load & (ex_rd != '0) & id_valid &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  // A redirect under a memory stall is frozen in EX and re-presents later.
  assign redirect_ok = ex_redirect & ex_valid & ~mem_stall;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch sequencer: stalls, bubbles, PC select and commit counter.
// Optional build macro PERF_CNT_EN adds hazard performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              dmem_busy,
  input  logic              imem_busy,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              wb_valid,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              fetch_discard,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_bubble,
  output logic              id_ex_bubble,
  output logic              mem_wb_bubble,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0]  inst_counter,
  output logic [CNT_W-1:0]  perf_load_use,
  output logic [CNT_W-1:0]  perf_mem_stall,
  output logic [CNT_W-1:0]  perf_flush
`else
  output logic [CNT_W-1:0]  inst_counter
`endif
);

  logic          mem_stall, load_use, redirect_ok;
  hazard_cause_t cause;
  ctrl_state_t   state_q, state_d;
  logic [ADDR_W-1:0] held_q, held_d;
  stage_ctrl_t   if_id_c, id_ex_c, mem_wb_c;
  logic          ex_mem_en_c;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .mem_valid   (mem_valid),
    .dmem_busy   (dmem_busy),
    .ex_redirect (ex_redirect),
    .mem_stall   (mem_stall),
    .load_use    (load_use),
    .redirect_ok (redirect_ok)
  );

  // Resolve which hazard wins this cycle.
  always_comb begin
    cause = CAUSE_NONE;
    if (mem_stall)        cause = CAUSE_MEM_STALL;
    else if (redirect_ok) cause = CAUSE_REDIRECT;
    else if (load_use)    cause = CAUSE_LOAD_USE;
    else if (imem_busy)   cause = CAUSE_FETCH_WAIT;
  end

  // Next-state and latch controls; HOLD overlays the held redirect on top.
  always_comb begin
    state_d       = state_q;
    held_d        = held_q;
    pc_en         = 1'b1;
    pc_redirect   = 1'b0;
    pc_target     = '0;
    fetch_discard = 1'b0;
    if_id_c       = '{en: 1'b1, bubble: 1'b0};
    id_ex_c       = '{en: 1'b1, bubble: 1'b0};
    mem_wb_c      = '{en: 1'b1, bubble: 1'b0};
    ex_mem_en_c   = 1'b1;

    case (cause)
      CAUSE_MEM_STALL: begin
        pc_en           = 1'b0;
        if_id_c.en      = 1'b0;
        id_ex_c.en      = 1'b0;
        ex_mem_en_c     = 1'b0;
        mem_wb_c.bubble = 1'b1;
      end
      CAUSE_REDIRECT: begin
        pc_redirect    = 1'b1;
        pc_target      = ex_target;
        if_id_c.bubble = 1'b1;
        id_ex_c.bubble = 1'b1;
      end
      CAUSE_LOAD_USE: begin
        pc_en          = 1'b0;
        if_id_c.en     = 1'b0;
        id_ex_c.bubble = 1'b1;
      end
      CAUSE_FETCH_WAIT: begin
        pc_en          = 1'b0;
        if_id_c.bubble = 1'b1;
      end
      default: ;
    endcase

    case (state_q)
      RUN: begin
        if (redirect_ok && imem_busy) begin
          state_d = HOLD;
          held_d  = ex_target;
        end
      end
      HOLD: begin
        // The outstanding fetch is wrong-path: keep steering to the target
        // and drop its response when it lands, even under a memory stall.
        pc_redirect    = 1'b1;
        if_id_c.bubble = 1'b1;
        pc_target      = redirect_ok ? ex_target : held_q;
        if (imem_busy) begin
          pc_en = 1'b0;
          if (redirect_ok) held_d = ex_target;
        end else begin
          pc_en         = 1'b1;
          fetch_discard = 1'b1;
          state_d       = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (!reset) begin
      pc_en         = 1'b0;
      pc_redirect   = 1'b0;
      pc_target     = '0;
      fetch_discard = 1'b0;
      if_id_c       = '{en: 1'b0, bubble: 1'b1};
      id_ex_c       = '{en: 1'b0, bubble: 1'b1};
      mem_wb_c      = '{en: 1'b0, bubble: 1'b1};
      ex_mem_en_c   = 1'b0;
    end
  end

  assign if_id_en      = if_id_c.en;
  assign if_id_bubble  = if_id_c.bubble;
  assign id_ex_en      = id_ex_c.en;
  assign id_ex_bubble  = id_ex_c.bubble;
  assign ex_mem_en     = ex_mem_en_c;
  assign mem_wb_en     = mem_wb_c.en;
  assign mem_wb_bubble = mem_wb_c.bubble;

  // FSM state and held redirect target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  // Committed-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        inst_counter <= '0;
    else if (wb_valid) inst_counter <= inst_counter + CNT_W'(1);
  end

`ifdef PERF_CNT_EN
  // Hazard counters, one count per cycle the hazard actually wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_load_use  <= '0;
      perf_mem_stall <= '0;
      perf_flush     <= '0;
    end else begin
      if (cause == CAUSE_LOAD_USE)  perf_load_use  <= perf_load_use + CNT_W'(1);
      if (cause == CAUSE_MEM_STALL) perf_mem_stall <= perf_mem_stall + CNT_W'(1);
      if (cause == CAUSE_REDIRECT)  perf_flush     <= perf_flush + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB, WB/commit).
- Each cycle, per latch: advance (enable) and/or bubble (load valid=0).
- Handles load-use stalls, data-memory wait stalls, fetch-wait bubbles and EX-stage redirects, including a redirect that arrives while an instruction fetch is outstanding.
- Owns the PC-select and the commit counter that tags instructions (inst_counter).

Parameters:
- ADDR_W, 64, PC/target width
- CNT_W, 64, width of commit/perf counters
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID latch valid
- id_rs1, id_rs2  in  REG_AW  source regs of instruction in ID
- ex_valid  in  1  ID/EX latch valid
- ex_is_load  in  1  instruction in EX is a load
- ex_rd  in  REG_AW  dest reg in EX
- mem_valid  in  1  EX/MEM latch valid
- dmem_busy  in  1  data access in MEM not yet complete
- imem_busy  in  1  fetch outstanding
- ex_redirect  in  1  EX resolved taken branch/jump
- ex_target  in  ADDR_W  redirect target
- wb_valid  in  1  WB/commit latch valid (retiring)
- pc_en  out  1  PC register update enable
- pc_redirect  out  1  select pc_target instead of pc+4
- pc_target  out  ADDR_W  redirect PC
- fetch_discard  out  1  drop the fetch response completing this cycle
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch enables
- if_id_bubble, id_ex_bubble, mem_wb_bubble  out  1 each  load valid=0 into latch
- inst_counter  out  CNT_W  number of committed instructions

Behaviour:
- Reset (reset=0, async):
  - All *_en=0; all *_bubble=1; pc_en=0; pc_redirect=0; pc_target=0; fetch_discard=0.
  - inst_counter=0; FSM=RUN.
- Conditions:
  - mem_stall = mem_valid & dmem_busy
  - load_use = ex_valid & ex_is_load & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2)
  - redirect_ok = ex_redirect & ex_valid & !mem_stall
- Priority, highest first:
  1. mem_stall: IF/ID, ID/EX, EX/MEM and PC frozen (en=0); mem_wb_en=1 with mem_wb_bubble=1; pending redirect ignored (it re-presents next cycle, since EX is frozen).
  2. redirect_ok: if_id_bubble=1, id_ex_bubble=1, all en=1, pc_redirect=1, pc_target=ex_target. Redirect overrides load_use.
  3. load_use: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_bubble=1; EX/MEM and MEM/WB advance.
  4. imem_busy: pc_en=0; if_id_en=1 with if_id_bubble=1; later stages advance.
  5. Otherwise: all en=1, bubbles=0, pc_en=1.
- FSM:
  - RUN: redirect_ok & imem_busy → latch target into held_target, go HOLD.
  - HOLD:
    - pc_redirect=1, pc_target=held_target, pc_en=0, if_id_bubble=1.
    - When !imem_busy: fetch_discard=1 for that cycle, pc_en=1, return to RUN.
    - A new redirect_ok in HOLD overwrites held_target and stays in HOLD.
- Combinational outputs; enables take effect on the same-cycle clock edge.
- inst_counter increments by 1 on each clock with wb_valid=1; wraps modulo 2^CNT_W.
- Reset mid-HOLD discards the held target; no discard pulse is produced.

Optional Feature:
- PERF_CNT_EN defined:
  - Adds outputs perf_load_use, perf_mem_stall, perf_flush (CNT_W each), reset to 0.
  - Each increments once per cycle in which load_use (effective, i.e. not overridden), mem_stall or redirect_ok respectively is acted on.
  - Wrap modulo 2^CNT_W.
- Undefined: no ports, no counter flops.

Decomposition:
- Package pipe_ctrl_pkg:
  - enum ctrl_state_t {RUN, HOLD}
  - struct stage_ctrl_t {en, bubble}
  - hazard-cause enum for debug
- Reuse existing word_t/addr_t/reg_addr from common.
- One sub-module, hazard_detect: purely combinational load_use/mem_stall/redirect_ok; FSM and counters stay in the top.

Test Plan:
- Load-use: EX load rd=5, ID rs2=5 → one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1; proceeds next cycle. Same with rd=0 → no stall.
- dmem_busy held 3 cycles with mem_valid=1 → 3 cycles of IF/ID, ID/EX, EX/MEM en=0 and mem_wb_bubble=1; simultaneous ex_redirect is not acted on until the 4th cycle.
- Redirect, imem idle, ex_target=0x8000_0040 → pc_redirect=1, pc_target=0x8000_0040, if_id_bubble=id_ex_bubble=1, single cycle.
- Redirect with imem_busy for 2 more cycles → HOLD; pc_target held; fetch_discard=1 exactly on the completion cycle; then RUN.
- Redirect and load_use in the same cycle → redirect behaviour only, no load-use stall.
- 10 cycles of wb_valid=1 → inst_counter=10; async reset asserted mid-run → counter 0 and all bubbles=1 immediately, without a clock edge.
